// File: rtl/biu_wb_bridge_if.sv
// Bus bundle for the CPU-side BIU: CPU data port, Wishbone master port and MIO port.
// The bridge takes the master view; the environment (CPU, WB slave, MIO) takes the slave view.
interface biu_wb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              Cpu_req_i;
  logic              Cpu_mem_w_i;
  logic [1:0]        Cpu_size_i;
  logic [ADDR_W-1:0] Cpu_addr_i;
  logic [DATA_W-1:0] Cpu_data_i;
  logic [DATA_W-1:0] Cpu_data_o;
  logic              Cpu_ready_o;
  logic              Cpu_err_o;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [ADDR_W-1:0] wb_adr_o;
  logic [3:0]        wb_sel_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i, wb_err_i, wb_rty_i, wb_gnt_i;
  logic              MIO_req_o, MIO_mem_w_o;
  logic [ADDR_W-1:0] MIO_addr_o;
  logic [DATA_W-1:0] MIO_data_o;
  logic [DATA_W-1:0] MIO_data_i;
  logic              MIO_ready_i;

  modport master (
    input  Cpu_req_i, Cpu_mem_w_i, Cpu_size_i, Cpu_addr_i, Cpu_data_i,
    output Cpu_data_o, Cpu_ready_o, Cpu_err_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_gnt_i,
    output MIO_req_o, MIO_mem_w_o, MIO_addr_o, MIO_data_o,
    input  MIO_data_i, MIO_ready_i
  );

  modport slave (
    output Cpu_req_i, Cpu_mem_w_i, Cpu_size_i, Cpu_addr_i, Cpu_data_i,
    input  Cpu_data_o, Cpu_ready_o, Cpu_err_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_gnt_i,
    input  MIO_req_o, MIO_mem_w_o, MIO_addr_o, MIO_data_o,
    output MIO_data_i, MIO_ready_i
  );
endinterface

// File: rtl/biu_wb_bridge.sv
// CPU data-port BIU: region decode to MIO or arbitrated Wishbone, with retry back-off,
// retry limit and watchdog timeout on the Wishbone side. One ready pulse per transfer.
module biu_wb_bridge #(
  parameter int                     ADDR_W      = 32,
  parameter int                     DATA_W      = 32,
  parameter int                     REGION_BITS = 4,
  parameter logic [REGION_BITS-1:0] WB_REGION   = 4'h3,
  parameter int                     TIMEOUT     = 255,
  parameter int                     MAX_RETRY   = 3
) (
  input logic           clk,
  input logic           rst,
  biu_wb_bridge_if.master bus
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRY);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WB_WAIT    = 3'd1;
  localparam logic [2:0] S_WB_BACKOFF = 3'd2;
  localparam logic [2:0] S_MIO_WAIT   = 3'd3;
  localparam logic [2:0] S_RESP       = 3'd4;

  typedef struct packed {
    logic                 we;
    logic [NUM_LANES-1:0] sel;
    logic [ADDR_W-1:0]    adr;
    logic [DATA_W-1:0]    dat;
  } req_t;

  logic [2:0]    state;
  req_t          req_q;
  logic [TW-1:0] timer;
  logic [RW-1:0] rty_cnt;
  logic          cyc_q, mio_req_q, ready_q, err_q;
  logic [DATA_W-1:0] rdata_q;

  logic [NUM_LANES-1:0][7:0] lane_dat;
  logic [NUM_LANES-1:0]      lane_sel;

  // Byte lanes: replicate right-aligned write data and pick the addressed lanes.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_dat[i] = (bus.Cpu_size_i == 2'd0) ? bus.Cpu_data_i[7:0] :
                         (bus.Cpu_size_i == 2'd1) ? bus.Cpu_data_i[8*(i%2) +: 8] :
                                                    bus.Cpu_data_i[8*i +: 8];
    assign lane_sel[i] = (bus.Cpu_size_i == 2'd0) ? (bus.Cpu_addr_i[1:0] == 2'(i)) :
                         (bus.Cpu_size_i == 2'd1) ? (bus.Cpu_addr_i[1] == 1'(i / 2)) :
                                                    1'b1;
  end

  logic to_wb;
  assign to_wb = (bus.Cpu_addr_i[ADDR_W-1 -: REGION_BITS] == WB_REGION);

  // Termination decode in priority err > ack > rty > timeout; grant gates everything.
  logic wb_ok, wb_fail, wb_retry;
  always_comb begin
    wb_ok    = 1'b0;
    wb_fail  = 1'b0;
    wb_retry = 1'b0;
    if (bus.wb_gnt_i && bus.wb_err_i)      wb_fail = 1'b1;
    else if (bus.wb_gnt_i && bus.wb_ack_i) wb_ok   = 1'b1;
    else if (bus.wb_gnt_i && bus.wb_rty_i) begin
      if (rty_cnt == RTY_MAX) wb_fail  = 1'b1;
      else                    wb_retry = 1'b1;
    end else if (timer == TMO_LAST)        wb_fail = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      req_q     <= '0;
      timer     <= '0;
      rty_cnt   <= '0;
      cyc_q     <= 1'b0;
      mio_req_q <= 1'b0;
      ready_q   <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        S_IDLE: if (bus.Cpu_req_i) begin
          req_q   <= '{we: bus.Cpu_mem_w_i, sel: lane_sel, adr: bus.Cpu_addr_i, dat: lane_dat};
          timer   <= '0;
          rty_cnt <= '0;
          if (to_wb) begin
            state <= S_WB_WAIT;
            cyc_q <= 1'b1;
          end else begin
            state     <= S_MIO_WAIT;
            mio_req_q <= 1'b1;
          end
        end
        S_WB_WAIT: begin
          if (wb_ok || wb_fail) begin
            cyc_q   <= 1'b0;
            state   <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= wb_fail;
            if (wb_ok)             rdata_q <= bus.wb_dat_i;
            else if (!req_q.we)    rdata_q <= '0;
          end else if (wb_retry) begin
            cyc_q   <= 1'b0;
            rty_cnt <= rty_cnt + 1'b1;
            state   <= S_WB_BACKOFF;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_WB_BACKOFF: begin
          state <= S_WB_WAIT;
          cyc_q <= 1'b1;
          timer <= '0;
        end
        S_MIO_WAIT: if (bus.MIO_ready_i) begin
          rdata_q   <= bus.MIO_data_i;
          mio_req_q <= 1'b0;
          state     <= S_RESP;
          ready_q   <= 1'b1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Cpu_data_o  = rdata_q;
  assign bus.Cpu_ready_o = ready_q;
  assign bus.Cpu_err_o   = err_q;
  assign bus.wb_cyc_o    = cyc_q;
  assign bus.wb_stb_o    = cyc_q;
  assign bus.wb_we_o     = req_q.we;
  assign bus.wb_adr_o    = req_q.adr;
  assign bus.wb_sel_o    = req_q.sel;
  assign bus.wb_dat_o    = req_q.dat;
  assign bus.MIO_req_o   = mio_req_q;
  assign bus.MIO_mem_w_o = req_q.we;
  assign bus.MIO_addr_o  = req_q.adr;
  assign bus.MIO_data_o  = req_q.dat;
endmodule

// File: tb/tb_biu_wb_bridge.sv
// Randomized bench for biu_wb_bridge: scripted WB/MIO slave behaviour per transfer,
// outcome, latency and bus fields predicted from the transfer rules.
module tb_biu_wb_bridge;
  localparam int TIMEOUT   = 8;
  localparam int MAX_RETRY = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  biu_wb_bridge_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  biu_wb_bridge #(.TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // Per-attempt slave script: 0 ack, 1 err, 2 rty, 3 silent, 4 ack without grant, 5 ack+err.
  int          att_kind [4];
  int          att_w    [4];
  logic [31:0] att_dat  [4];
  int          mio_w;
  logic [31:0] mio_dat;
  logic [31:0] mdl_data;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_slave();
    bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_rty_i = 0; bus.wb_gnt_i = 0;
    bus.wb_dat_i = 0; bus.MIO_ready_i = 0; bus.MIO_data_i = 0;
  endtask

  // Drive one WB slave cycle: scripted termination at index w, grant-less noise elsewhere.
  task automatic drive_wb(input int a, input int k);
    bus.wb_ack_i = 0; bus.wb_err_i = 0; bus.wb_rty_i = 0;
    bus.wb_dat_i = $urandom;
    if (k == att_w[a] && att_kind[a] != 3) begin
      bus.wb_gnt_i = (att_kind[a] != 4);
      case (att_kind[a])
        0, 4: begin bus.wb_ack_i = 1; bus.wb_dat_i = att_dat[a]; end
        1:    bus.wb_err_i = 1;
        2:    bus.wb_rty_i = 1;
        5:    begin bus.wb_ack_i = 1; bus.wb_err_i = 1; bus.wb_dat_i = att_dat[a]; end
        default: ;
      endcase
    end else begin
      bus.wb_gnt_i = 1'($urandom);
      if (!bus.wb_gnt_i) begin
        bus.wb_ack_i = 1'($urandom); bus.wb_err_i = 1'($urandom); bus.wb_rty_i = 1'($urandom);
      end
    end
  endtask

  // One CPU transfer; called at posedge+1, returns at posedge+1 one cycle after the ready pulse.
  task automatic xfer(input logic we, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] d);
    logic        is_wb, e, done, cyc_prev, bad_gap;
    logic [3:0]  x_sel;
    logic [31:0] x_dat;
    int lat, per, rty, n, a, k, nper, low_run;
    logic fin;

    is_wb = (addr[31:28] == 4'h3);
    case (size)
      2'd0:    begin x_sel = 4'b0001 << addr[1:0]; x_dat = {24'h0, d[7:0]} * 32'h0101_0101; end
      2'd1:    begin x_sel = addr[1] ? 4'b1100 : 4'b0011; x_dat = {16'h0, d[15:0]} * 32'h0001_0001; end
      default: begin x_sel = 4'b1111; x_dat = d; end
    endcase

    e = 0; lat = 1; per = 0;
    if (is_wb) begin
      rty = 0; fin = 0;
      for (int i = 0; i < 4 && !fin; i++) begin
        per++;
        if (att_kind[i] == 3 || att_kind[i] == 4 || att_w[i] >= TIMEOUT) begin
          lat += TIMEOUT; e = 1; fin = 1;
        end else begin
          lat += att_w[i] + 1;
          if (att_kind[i] == 1 || att_kind[i] == 5) begin e = 1; fin = 1; end
          else if (att_kind[i] == 0) begin mdl_data = att_dat[i]; fin = 1; end
          else if (rty == MAX_RETRY) begin e = 1; fin = 1; end
          else begin rty++; lat++; end
        end
      end
      if (e && !we) mdl_data = 0;
    end else begin
      lat = 2 + mio_w;
      mdl_data = mio_dat;
    end

    bus.Cpu_req_i = 1; bus.Cpu_mem_w_i = we; bus.Cpu_size_i = size;
    bus.Cpu_addr_i = addr; bus.Cpu_data_i = d;
    n = 0; nper = 0; a = -1; k = 0; done = 0; cyc_prev = 0; bad_gap = 0; low_run = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        // Request inputs change mid-transfer; the latched access must not.
        bus.Cpu_addr_i = $urandom; bus.Cpu_data_i = $urandom;
        bus.Cpu_mem_w_i = ~we; bus.Cpu_size_i = 2'($urandom);
      end
      if (bus.Cpu_ready_o) begin
        done = 1;
      end else if (is_wb) begin
        if (bus.wb_cyc_o && !cyc_prev) begin
          if (nper > 0 && low_run != 1) bad_gap = 1;
          if (nper == 0) begin
            chk("wb_adr", bus.wb_adr_o, addr);
            chk("wb_sel", bus.wb_sel_o, x_sel);
            chk("wb_dat", bus.wb_dat_o, x_dat);
            chk("wb_we", bus.wb_we_o, we);
          end
          nper++; if (a < 3) a++; k = 0; low_run = 0;
        end
        if (bus.wb_cyc_o) begin
          if (bus.wb_stb_o !== 1'b1) bad_gap = 1;
          drive_wb(a, k); k++;
        end else begin
          if (nper > 0) low_run++;
          clr_slave();
        end
        cyc_prev = bus.wb_cyc_o;
      end else if (bus.MIO_req_o) begin
        if (k == 0) begin
          chk("mio_adr", bus.MIO_addr_o, addr);
          chk("mio_dat", bus.MIO_data_o, x_dat);
          chk("mio_we", bus.MIO_mem_w_o, we);
        end
        bus.MIO_ready_i = (k == mio_w);
        bus.MIO_data_i  = (k == mio_w) ? mio_dat : $urandom;
        k++;
      end
    end
    clr_slave();
    bus.Cpu_req_i = 0;
    chk("ready_seen", done, 1);
    chk("latency", n, lat);
    chk("cpu_err", bus.Cpu_err_o, e);
    chk("cpu_data", bus.Cpu_data_o, mdl_data);
    if (is_wb) begin
      chk("wb_periods", nper, per);
      chk("wb_gap", bad_gap, 0);
    end
    @(posedge clk); #1;
    chk("ready_pulse", bus.Cpu_ready_o, 0);
    chk("idle_bus", {bus.wb_cyc_o, bus.MIO_req_o}, 0);
  endtask

  task automatic set_att(input int i, input int kind, input int w);
    att_kind[i] = kind; att_w[i] = w; att_dat[i] = $urandom;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1;
    bus.Cpu_req_i = 0; bus.Cpu_mem_w_i = 0; bus.Cpu_size_i = 0;
    bus.Cpu_addr_i = 0; bus.Cpu_data_i = 0;
    clr_slave();
    mdl_data = 0; mio_w = 0; mio_dat = 0;
    for (int i = 0; i < 4; i++) set_att(i, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {bus.wb_cyc_o, bus.wb_stb_o, bus.MIO_req_o, bus.Cpu_ready_o, bus.Cpu_err_o}, 0);
    chk("rst_data", bus.Cpu_data_o, 0);
    chk("rst_adr", bus.wb_adr_o, 0);
    #4 rst = 0;
    @(posedge clk); #1;

    // Word read, ack two cycles after strobe.
    set_att(0, 0, 2);
    xfer(0, 2'd2, 32'h3000_0010, 32'h0);
    // Byte write to MIO.
    mio_w = 1; mio_dat = $urandom;
    xfer(1, 2'd0, 32'h0000_0003, 32'h0000_00AB);
    // Half write upper half, byte at offset 1.
    set_att(0, 0, 0);
    xfer(1, 2'd1, 32'h3000_0002, 32'h1234_5678);
    set_att(0, 0, 1);
    xfer(1, 2'd0, 32'h3000_0001, 32'h0000_005A);
    // Slave always retries: retry limit error.
    for (int i = 0; i < 4; i++) set_att(i, 2, i);
    xfer(0, 2'd2, 32'h3000_0100, 32'h0);
    // Silent slave, ack without grant, ack+err together.
    set_att(0, 3, 0);
    xfer(0, 2'd2, 32'h3000_0200, 32'h0);
    set_att(0, 4, 1);
    xfer(1, 2'd3, 32'h3000_0204, 32'hDEAD_BEEF);
    set_att(0, 5, 0);
    xfer(0, 2'd2, 32'h3000_0208, 32'h0);

    // Reset in the middle of a Wishbone wait.
    set_att(0, 3, 0);
    bus.Cpu_req_i = 1; bus.Cpu_mem_w_i = 0; bus.Cpu_size_i = 2'd2; bus.Cpu_addr_i = 32'h3000_0040;
    bus.wb_gnt_i = 1;
    repeat (3) @(posedge clk);
    #1 chk("rst_pre_cyc", bus.wb_cyc_o, 1);
    #2 rst = 1;
    #1 chk("rst_mid_drop", {bus.wb_cyc_o, bus.wb_stb_o, bus.Cpu_ready_o}, 0);
    bus.Cpu_req_i = 0; clr_slave();
    @(posedge clk); #1 rst = 0; mdl_data = 0;
    @(posedge clk); #1;
    set_att(0, 0, 0);
    xfer(0, 2'd2, 32'h3000_0044, 32'h0);

    for (int t = 0; t < 40; t++) begin
      logic [31:0] ad;
      ad = $urandom;
      ad[31:28] = ($urandom_range(0, 1) == 1) ? 4'h3 : 4'($urandom_range(4, 15));
      for (int i = 0; i < 4; i++) set_att(i, $urandom_range(0, 5), $urandom_range(0, 9));
      mio_w = $urandom_range(0, 4); mio_dat = $urandom;
      xfer(1'($urandom), 2'($urandom), ad, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
